counter_cmd_sched: RTL

- Command scheduler that shares one `contador32bits` 32-bit counter between two requesters.
- Each requester submits a command: counter mode, 4-bit load value and a run length.
- The block grants commands round-robin, drives the counter's enable/mode/D for the commanded number of cycles, and returns a completion record with the final count.
- It sits between requester logic and the counter instance, as the counter's only driver.

---
 rtl/counter_sched_pkg.sv | 18 +
 rtl/counter_cmd_sched_rr_arb2.sv | 24 ++
 rtl/counter_cmd_sched.sv | 104 ++++++++++
 3 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter command scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_REPORT
  } sched_state_t;

  // Counting modes of the shared contador32bits instance
  localparam logic [1:0] MODE_UP1   = 2'b00;
  localparam logic [1:0] MODE_DOWN1 = 2'b01;
  localparam logic [1:0] MODE_DOWN3 = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam int unsigned N_REQ = 2;

endpackage

// File: rtl/counter_cmd_sched_rr_arb2.sv
// Two-way round-robin arbiter; grant is one-hot or zero and only issued while enabled.
module rr_arb2
  import counter_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req_valid,
  input  logic             ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);

  // ptr names the requester that wins when both are pending
  always_comb begin
    grant = '0;
    if (en) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/counter_cmd_sched.sv
// Shares one contador32bits between two requesters: round-robin grant, timed run,
// completion report carrying the final count.
module counter_cmd_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned Q_W         = 32,
  parameter bit          STOP_ON_RCO = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [3:0]         req_mode,
  input  logic [7:0]         req_d,
  input  logic [2*LEN_W-1:0] req_len,
  output logic               cnt_enable,
  output logic [1:0]         cnt_mode,
  output logic [3:0]         cnt_d,
  input  logic               cnt_rco,
  input  logic [Q_W-1:0]     cnt_q,
  output logic               done,
  output logic               done_id,
  output logic [Q_W-1:0]     done_q,
  output logic               done_rco
);

  sched_state_t     state;
  logic             ptr;
  logic             owner;
  logic             rco_flag;
  logic [LEN_W-1:0] rem;
  logic [N_REQ-1:0] grant;
  logic             gid;
  logic [LEN_W-1:0] sel_len;
  logic [1:0]       sel_mode;
  logic [3:0]       sel_d;
  logic             rco_stop;

  rr_arb2 u_arb (
    .req_valid (req_valid),
    .ptr       (ptr),
    .en        ((state == S_IDLE) && !reset),
    .grant     (grant)
  );

  assign req_ready = grant;
  assign gid       = grant[1];
  assign sel_len   = gid ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
  assign sel_mode  = gid ? req_mode[3:2] : req_mode[1:0];
  assign sel_d     = gid ? req_d[7:4] : req_d[3:0];

  // rco cuts the enable in the same cycle so no extra count slips through
  assign rco_stop   = STOP_ON_RCO && cnt_rco;
  assign cnt_enable = (state == S_RUN) && !rco_stop;

  assign done     = (state == S_REPORT);
  assign done_id  = done && owner;
  assign done_q   = done ? cnt_q : '0;
  assign done_rco = done && rco_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      rco_flag <= 1'b0;
      rem      <= '0;
      cnt_mode <= '0;
      cnt_d    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|grant) begin
            ptr      <= ~gid;
            owner    <= gid;
            rem      <= sel_len;
            rco_flag <= 1'b0;
            // counter controls only change for a command that actually runs
            if (sel_len != '0) begin
              cnt_mode <= sel_mode;
              cnt_d    <= sel_d;
              state    <= S_RUN;
            end else begin
              state    <= S_REPORT;
            end
          end
        end
        S_RUN: begin
          if (rco_stop) begin
            rco_flag <= 1'b1;
            state    <= S_REPORT;
          end else begin
            rem <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) state <= S_REPORT;
          end
        end
        S_REPORT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
